// File: rtl/pc_stack_if.sv
// pc_stack_if: command and stack-status signals of the program-counter unit
interface pc_stack_if #(parameter int AW = 8, parameter int DEPTH = 4);
  logic lp, cp, ep, call, ret;
  logic [AW-1:0] top;
  logic [$clog2(DEPTH+1)-1:0] level;
  logic full, empty, ovf, unf;
  modport master(output lp, cp, ep, call, ret, input top, level, full, empty, ovf, unf);
  modport slave(input lp, cp, ep, call, ret, output top, level, full, empty, ovf, unf);
endinterface

// File: rtl/pc_stack.sv
// pc_stack: program counter with a multi-level circular subroutine return stack
module pc_stack #(
  parameter int AW = 8,
  parameter int DEPTH = 4,
  parameter int OVF_MODE = 0,
  parameter logic [AW-1:0] RESET_ADDR = '0
) (
  input  logic clk,
  input  logic clr,
  inout  wire [AW-1:0] bus,
  pc_stack_if.slave s
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [AW-1:0] pc;
  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] wp, wp_inc, wp_dec;
  logic [LW-1:0] lvl;
  logic full, empty, push, ovf, unf;
  // wp is the next write slot; the top entry sits one below it, modulo DEPTH
  assign wp_inc = wp == PW'(DEPTH-1) ? '0 : wp + 1'b1;
  assign wp_dec = wp == '0 ? PW'(DEPTH-1) : wp - 1'b1;
  assign empty = lvl == '0;
  assign full = lvl == LW'(DEPTH);
  assign push = ~s.ret & s.call & (~full | (OVF_MODE != 0));
  assign bus = s.ep & ~s.lp & ~s.call ? pc : 'z;
  assign s.top = empty ? '0 : mem[wp_dec];
  assign s.level = lvl;
  assign s.full = full;
  assign s.empty = empty;
  assign s.ovf = ovf;
  assign s.unf = unf;
  always_ff @(posedge clk) begin
    if (clr) begin
      pc <= RESET_ADDR;
      lvl <= '0;
      wp <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (s.ret) begin
      if (empty) unf <= 1'b1;
      else begin
        pc <= mem[wp_dec];
        wp <= wp_dec;
        lvl <= lvl - 1'b1;
      end
    end else if (s.call) begin
      if (full) ovf <= 1'b1;
      if (push) begin
        pc <= bus;
        wp <= wp_inc;
        if (!full) lvl <= lvl + 1'b1;
      end
    end else if (s.lp) pc <= bus;
    else if (s.cp) pc <= pc + 1'b1;
  end
  always_ff @(posedge clk)
    if (push & ~clr) mem[wp] <= pc;
endmodule

// File: tb/tb_pc_stack.sv
// tb_pc_stack: table-driven check of a reject-mode and a circular-mode pc_stack
module tb_pc_stack;
  logic clk = 1'b0, clr = 1'b0, ret = 1'b0, call = 1'b0, lp = 1'b0, cp = 1'b0, ep = 1'b0;
  logic [7:0] tgt = 8'h00;
  wire [7:0] bus0, bus1;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  pc_stack_if #(.AW(8), .DEPTH(4)) i0(), i1();
  assign bus0 = (lp | call) ? tgt : 'z;
  assign bus1 = (lp | call) ? tgt : 'z;
  assign {i0.ret, i0.call, i0.lp, i0.cp, i0.ep} = {ret, call, lp, cp, ep};
  assign {i1.ret, i1.call, i1.lp, i1.cp, i1.ep} = {ret, call, lp, cp, ep};
  pc_stack #(.AW(8), .DEPTH(4), .OVF_MODE(0), .RESET_ADDR(8'h10)) u0 (.clk(clk), .clr(clr), .bus(bus0), .s(i0.slave));
  pc_stack #(.AW(8), .DEPTH(4), .OVF_MODE(1), .RESET_ADDR(8'h10)) u1 (.clk(clk), .clr(clr), .bus(bus1), .s(i1.slave));
  typedef struct {
    logic c, r, k, l, p;
    logic [7:0] tgt;
    logic [7:0] p0, t0;
    logic [2:0] l0;
    logic o0, u0;
    logic [7:0] p1, t1;
    logic [2:0] l1;
    logic o1, u1;
  } vec_t;
  vec_t vq[$];
  task automatic add(input logic c, r, k, l, p, input logic [7:0] tg,
                     input logic [7:0] p0, input logic [2:0] l0, input logic [7:0] t0, input logic o0, u0,
                     input logic [7:0] p1, input logic [2:0] l1, input logic [7:0] t1, input logic o1, u1);
    vec_t x;
    x.c = c; x.r = r; x.k = k; x.l = l; x.p = p; x.tgt = tg;
    x.p0 = p0; x.l0 = l0; x.t0 = t0; x.o0 = o0; x.u0 = u0;
    x.p1 = p1; x.l1 = l1; x.t1 = t1; x.o1 = o1; x.u1 = u1;
    vq.push_back(x);
  endtask
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask
  task automatic apply(input int i, input vec_t x);
    {clr, ret, call, lp, cp} = {x.c, x.r, x.k, x.l, x.p};
    tgt = x.tgt;
    ep = 1'b0;
    @(posedge clk);
    #1 {clr, ret, call, lp, cp} = '0;
    ep = 1'b1;
    #1;
    chk($sformatf("v%0d pc0", i), bus0, x.p0);
    chk($sformatf("v%0d level0", i), 8'(i0.level), 8'(x.l0));
    chk($sformatf("v%0d top0", i), i0.top, x.t0);
    chk($sformatf("v%0d ovf0", i), 8'(i0.ovf), 8'(x.o0));
    chk($sformatf("v%0d unf0", i), 8'(i0.unf), 8'(x.u0));
    chk($sformatf("v%0d full0", i), 8'(i0.full), 8'(x.l0 == 3'd4));
    chk($sformatf("v%0d empty0", i), 8'(i0.empty), 8'(x.l0 == 3'd0));
    chk($sformatf("v%0d pc1", i), bus1, x.p1);
    chk($sformatf("v%0d level1", i), 8'(i1.level), 8'(x.l1));
    chk($sformatf("v%0d top1", i), i1.top, x.t1);
    chk($sformatf("v%0d ovf1", i), 8'(i1.ovf), 8'(x.o1));
    chk($sformatf("v%0d unf1", i), 8'(i1.unf), 8'(x.u1));
    chk($sformatf("v%0d full1", i), 8'(i1.full), 8'(x.l1 == 3'd4));
    chk($sformatf("v%0d empty1", i), 8'(i1.empty), 8'(x.l1 == 3'd0));
  endtask
  initial begin
    //   c r k l p tgt    pc0  l0 top0 o u    pc1  l1 top1 o u
    add(1,0,0,0,0,8'h00, 8'h10,0,8'h00,0,0, 8'h10,0,8'h00,0,0);
    add(0,0,0,0,1,8'h00, 8'h11,0,8'h00,0,0, 8'h11,0,8'h00,0,0);
    add(0,0,0,0,1,8'h00, 8'h12,0,8'h00,0,0, 8'h12,0,8'h00,0,0);
    add(0,0,0,0,1,8'h00, 8'h13,0,8'h00,0,0, 8'h13,0,8'h00,0,0);
    add(0,0,0,1,0,8'h05, 8'h05,0,8'h00,0,0, 8'h05,0,8'h00,0,0);
    add(0,0,1,0,0,8'h40, 8'h40,1,8'h05,0,0, 8'h40,1,8'h05,0,0);
    add(0,1,0,0,0,8'h00, 8'h05,0,8'h00,0,0, 8'h05,0,8'h00,0,0);
    add(0,0,0,1,0,8'h01, 8'h01,0,8'h00,0,0, 8'h01,0,8'h00,0,0);
    add(0,0,1,0,0,8'h02, 8'h02,1,8'h01,0,0, 8'h02,1,8'h01,0,0);
    add(0,0,1,0,0,8'h03, 8'h03,2,8'h02,0,0, 8'h03,2,8'h02,0,0);
    add(0,0,1,0,0,8'h04, 8'h04,3,8'h03,0,0, 8'h04,3,8'h03,0,0);
    add(0,0,1,0,0,8'h05, 8'h05,4,8'h04,0,0, 8'h05,4,8'h04,0,0);
    add(0,0,1,0,0,8'h06, 8'h05,4,8'h04,1,0, 8'h06,4,8'h05,1,0);
    add(0,1,0,0,0,8'h00, 8'h04,3,8'h03,1,0, 8'h05,3,8'h04,1,0);
    add(0,1,0,0,0,8'h00, 8'h03,2,8'h02,1,0, 8'h04,2,8'h03,1,0);
    add(0,1,0,0,0,8'h00, 8'h02,1,8'h01,1,0, 8'h03,1,8'h02,1,0);
    add(0,1,0,0,0,8'h00, 8'h01,0,8'h00,1,0, 8'h02,0,8'h00,1,0);
    add(0,1,0,0,0,8'h00, 8'h01,0,8'h00,1,1, 8'h02,0,8'h00,1,1);
    add(0,0,0,1,0,8'h22, 8'h22,0,8'h00,1,1, 8'h22,0,8'h00,1,1);
    add(0,0,1,0,0,8'h30, 8'h30,1,8'h22,1,1, 8'h30,1,8'h22,1,1);
    add(0,1,1,1,1,8'h99, 8'h22,0,8'h00,1,1, 8'h22,0,8'h00,1,1);
    add(0,0,0,1,0,8'hFF, 8'hFF,0,8'h00,1,1, 8'hFF,0,8'h00,1,1);
    add(0,0,0,0,1,8'h00, 8'h00,0,8'h00,1,1, 8'h00,0,8'h00,1,1);
    add(0,0,1,0,0,8'h50, 8'h50,1,8'h00,1,1, 8'h50,1,8'h00,1,1);
    add(0,0,1,0,0,8'h60, 8'h60,2,8'h50,1,1, 8'h60,2,8'h50,1,1);
    add(1,0,1,0,0,8'h70, 8'h10,0,8'h00,0,0, 8'h10,0,8'h00,0,0);
    add(0,0,0,1,1,8'h33, 8'h33,0,8'h00,0,0, 8'h33,0,8'h00,0,0);
    add(0,0,1,1,0,8'h44, 8'h44,1,8'h33,0,0, 8'h44,1,8'h33,0,0);
    foreach (vq[i]) apply(i, vq[i]);
    // ep with lp: the unit must release the bus so the target is seen
    lp = 1'b1; tgt = 8'hAB;
    #1 chk("ep_lp bus0", bus0, 8'hAB);
    chk("ep_lp bus1", bus1, 8'hAB);
    lp = 1'b0;
    // ep with ret drives the PC from before the pop
    ret = 1'b1;
    #1 chk("ep_ret bus0", bus0, 8'h44);
    chk("ep_ret bus1", bus1, 8'h44);
    @(posedge clk);
    #1 ret = 1'b0;
    #1 chk("ret pc0", bus0, 8'h33);
    chk("ret level0", 8'(i0.level), 8'h00);
    chk("ret pc1", bus1, 8'h33);
    chk("ret top1", i1.top, 8'h00);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
